// File: rtl/ascii_dec_stream_to_int.sv
// ---------------------------------------------------------------------------
// ascii_dec_stream_to_int
//
// Streaming ASCII-decimal to binary converter. Characters arrive one per
// cycle on a valid/ready input handshake. Up to MAX_DIGITS decimal digits
// are accumulated per string, and the string ends with the character flagged
// by in_last. One result per string is then offered on a valid/ready output
// handshake. The result carries the binary value, an error flag for
// malformed strings and the number of digits accumulated.
//
// Optional feature macro: SIGNED_INPUT_EN
//   defined   : a leading '-' marks the string negative. The result is the
//               two's complement of the accumulated magnitude.
//   undefined : '-' is an ordinary illegal character and there is no sign
//               state at all.
//
// Parameters
//   MAX_DIGITS  maximum digits accepted per string (1..18)
//   OUT_W       result width. It must hold 10^MAX_DIGITS-1, plus one sign
//               bit when SIGNED_INPUT_EN is defined. Any other combination
//               stops elaboration.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; clears all state
//   in_valid     in_char/in_last are presented
//   in_ready     converter can take a character (registered)
//   in_char      ASCII character
//   in_last      in_char is the final character of the string
//   out_valid    result available (registered)
//   out_ready    consumer takes the result
//   out_val      converted value; two's complement when negative; 0 on error
//   out_err      string was malformed
//   out_ndigits  digits accumulated, saturating at MAX_DIGITS
// ---------------------------------------------------------------------------
module ascii_dec_stream_to_int #(
  parameter int MAX_DIGITS = 4,
  parameter int OUT_W      = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [7:0]                        in_char,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_W-1:0]                  out_val,
  output logic                              out_err,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   out_ndigits
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

`ifdef SIGNED_INPUT_EN
  localparam int SIGN_W = 1;
`else
  localparam int SIGN_W = 0;
`endif

  // Bits needed to hold the largest MAX_DIGITS-digit number, 10^digits - 1.
  function automatic int digits_to_bits(input int digits);
    logic [63:0] lim;
    int          bits;
    lim = 64'd1;
    for (int i = 0; i < digits; i++) lim = lim * 64'd10;
    lim  = lim - 64'd1;
    bits = 0;
    while (bits < 64 && (lim >> bits) != 64'd0) bits++;
    return bits;
  endfunction

  localparam int NEED_W = digits_to_bits(MAX_DIGITS) + SIGN_W;

  // A result that is too narrow would silently wrap acc*10+d. Reject such
  // parameter sets at elaboration instead.
  if (MAX_DIGITS < 1 || MAX_DIGITS > 18 || OUT_W < NEED_W) begin : g_param_check
    $error("ascii_dec_stream_to_int: OUT_W=%0d cannot hold %0d digits (needs %0d)",
           OUT_W, MAX_DIGITS, NEED_W);
  end

  typedef enum logic {
    S_ACC = 1'b0,   // accepting characters of a string
    S_OUT = 1'b1    // holding a result for the consumer
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e             state_q,       state_d;
  logic [OUT_W-1:0]   acc_q,         acc_d;
  logic [CNT_W-1:0]   cnt_q,         cnt_d;
  logic               err_q,         err_d;
`ifdef SIGNED_INPUT_EN
  logic               neg_q,         neg_d;
  logic               first_q,       first_d;
`endif

  // Registered outputs. They are updated together with the state, so no
  // input reaches an output without passing a flop.
  logic               in_ready_q,    in_ready_d;
  logic               out_valid_q,   out_valid_d;
  logic [OUT_W-1:0]   out_val_q,     out_val_d;
  logic               out_err_q,     out_err_d;
  logic [CNT_W-1:0]   out_ndigits_q, out_ndigits_d;

  // -------------------------------------------------------------------------
  // Character classification
  // -------------------------------------------------------------------------
  logic             accept;
  logic             is_digit;
  logic             at_max;
  logic [OUT_W-1:0] digit_val;

  assign accept    = in_valid && in_ready_q && (state_q == S_ACC);
  assign is_digit  = (in_char >= 8'h30) && (in_char <= 8'h39);
  // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value.
  assign digit_val = OUT_W'(in_char[3:0]);
  assign at_max    = (cnt_q == CNT_W'(MAX_DIGITS));

`ifdef SIGNED_INPUT_EN
  logic is_minus;
  assign is_minus = (in_char == 8'h2D);
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first. Then
    // no path leaves a value unassigned, and no latch is inferred.
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
`ifdef SIGNED_INPUT_EN
    neg_d         = neg_q;
    first_d       = first_q;
`endif
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_val_d     = out_val_q;
    out_err_d     = out_err_q;
    out_ndigits_d = out_ndigits_q;

    unique case (state_q)
      S_ACC: begin
        // in_ready comes up one cycle after reset or after a handshake.
        in_ready_d = 1'b1;
        if (accept) begin
          if (is_digit) begin
            if (!at_max) begin
              acc_d = acc_q * OUT_W'(10) + digit_val;
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              err_d = 1'b1;   // too many digits; the value is frozen
            end
`ifdef SIGNED_INPUT_EN
          end else if (is_minus && first_q) begin
            neg_d = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
`ifdef SIGNED_INPUT_EN
          first_d = 1'b0;
`endif

          if (in_last) begin
            // A string without any digit ("-" or "x") is malformed.
            if (cnt_d == '0) err_d = 1'b1;

            state_d       = S_OUT;
            in_ready_d    = 1'b0;
            out_valid_d   = 1'b1;
            out_err_d     = err_d;
            out_ndigits_d = cnt_d;
            if (err_d) begin
              out_val_d = '0;
            end else begin
`ifdef SIGNED_INPUT_EN
              out_val_d = neg_d ? (-acc_d) : acc_d;
`else
              out_val_d = acc_d;
`endif
            end
          end
        end
      end

      S_OUT: begin
        // The outputs stay untouched until the consumer takes them.
        if (out_ready) begin
          state_d     = S_ACC;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          err_d       = 1'b0;
`ifdef SIGNED_INPUT_EN
          neg_d       = 1'b0;
          first_d     = 1'b1;
`endif
        end
      end

      default: begin
        state_d = S_ACC;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every flop here is architecturally visible, so all of them
      // are reset. The design holds no storage array that could stay
      // unreset.
      state_q       <= S_ACC;
      acc_q         <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
`ifdef SIGNED_INPUT_EN
      neg_q         <= 1'b0;
      first_q       <= 1'b1;
`endif
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_val_q     <= '0;
      out_err_q     <= 1'b0;
      out_ndigits_q <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
`ifdef SIGNED_INPUT_EN
      neg_q         <= neg_d;
      first_q       <= first_d;
`endif
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_val_q     <= out_val_d;
      out_err_q     <= out_err_d;
      out_ndigits_q <= out_ndigits_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_val     = out_val_q;
  assign out_err     = out_err_q;
  assign out_ndigits = out_ndigits_q;

endmodule
